register_file: RTL

REGISTER_FILE -- requirements
Module: register_file

---
 rtl/register_file_pkg.sv | 31 +++
 rtl/register32.sv | 36 +++
 rtl/register_file.sv | 46 ++++
 3 files changed

// File: rtl/register_file_pkg.sv
// register_file_pkg: shared encodings for the register file.
//   fun_sel_e - register operation codes carried on FunSel
//   reg_sel_e - 3-bit source select codes for OutASel / OutBSel
package register_file_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned NUM_REGS = 8;

  typedef enum logic [2:0] {
    DEC   = 3'b000,
    INC   = 3'b001,
    LOAD  = 3'b010,
    CLR   = 3'b011,
    LDB_Z = 3'b100,
    LDH_K = 3'b101,
    SHB   = 3'b110,
    LDH_S = 3'b111
  } fun_sel_e;

  typedef enum logic [2:0] {
    SEL_R1 = 3'b000,
    SEL_R2 = 3'b001,
    SEL_R3 = 3'b010,
    SEL_R4 = 3'b011,
    SEL_S1 = 3'b100,
    SEL_S2 = 3'b101,
    SEL_S3 = 3'b110,
    SEL_S4 = 3'b111
  } reg_sel_e;

endpackage

// File: rtl/register32.sv
// register32: one 32-bit storage element with a small operation set.
//   Clock  - rising-edge clock
//   Reset  - synchronous active-high clear, overrides E
//   E      - operation enable; when low the register holds
//   FunSel - operation code (fun_sel_e)
//   I      - write data
//   Q      - current register contents
module register32
  import register_file_pkg::*;
(
  input  logic                Clock,
  input  logic                Reset,
  input  logic                E,
  input  logic [2:0]          FunSel,
  input  logic [DATA_W-1:0]   I,
  output logic [DATA_W-1:0]   Q
);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      Q <= '0;
    end else if (E) begin
      case (fun_sel_e'(FunSel))
        DEC:   Q <= Q - 32'd1;
        INC:   Q <= Q + 32'd1;
        LOAD:  Q <= I;
        CLR:   Q <= '0;
        LDB_Z: Q <= {24'b0, I[7:0]};
        LDH_K: Q <= {Q[31:16], I[15:0]};
        SHB:   Q <= {Q[23:0], I[7:0]};
        LDH_S: Q <= {{16{I[15]}}, I[15:0]};
      endcase
    end
  end

endmodule

// File: rtl/register_file.sv
// register_file: four general (R1-R4) and four scratch (S1-S4) 32-bit
// registers with two independent combinational read ports.
//   Clock, Reset     - clock and synchronous active-high reset
//   I                - write data
//   OutASel, OutBSel - read selects (000..011 = R1..R4, 100..111 = S1..S4)
//   FunSel           - operation applied to every enabled register
//   RegSel, ScrSel   - per-register enables (bit0 = R1/S1)
//   OutA, OutB       - selected register contents
module register_file
  import register_file_pkg::*;
(
  input  logic                Clock,
  input  logic                Reset,
  input  logic [DATA_W-1:0]   I,
  input  logic [2:0]          OutASel,
  input  logic [2:0]          OutBSel,
  input  logic [2:0]          FunSel,
  input  logic [3:0]          RegSel,
  input  logic [3:0]          ScrSel,
  output logic [DATA_W-1:0]   OutA,
  output logic [DATA_W-1:0]   OutB
);

  // Enable index matches the read select code, so one array serves both.
  logic [NUM_REGS-1:0] en;
  logic [DATA_W-1:0]   q [NUM_REGS];

  assign en = {ScrSel, RegSel};

  for (genvar k = 0; k < NUM_REGS; k++) begin : g_reg
    register32 u_reg (
      .Clock  (Clock),
      .Reset  (Reset),
      .E      (en[k]),
      .FunSel (FunSel),
      .I      (I),
      .Q      (q[k])
    );
  end

  always_comb begin
    OutA = q[OutASel];
    OutB = q[OutBSel];
  end

endmodule
